approx_adder_err_monitor: RTL and testbench

// - Consumer/checker end of the approximate-adder stimulus path: accepts a stream of
//   (A, B, approximate sum) samples and accumulates error statistics against the exact sum.
// - Sits behind the N=16 approximate adder (K=12 approximate low part) in hardware

---
 rtl/approx_adder_err_monitor.sv | 178 +++++++++++++++++
 tb/tb_approx_adder_err_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_err_monitor.sv
// Error-statistics checker for an approximate adder: 2-stage pipeline, stats visible 3 cycles after accept.
// Sustains one sample/cycle; in_ready_o is deasserted outside RUN or once target samples are accepted.
module approx_adder_err_monitor #(
  parameter int N     = 16,
  parameter int K     = 12,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] target_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     in_a_i,
  input  logic [N-1:0]     in_b_i,
  input  logic [N-1:0]     in_sum_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] samples_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] low_err_cnt_o,
  output logic [ACC_W-1:0] ed_sum_o,
  output logic [N:0]       ed_max_o,
  output logic [N-1:0]     max_a_o,
  output logic [N-1:0]     max_b_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] target_q, accepted_q;
  logic             accept, start_ok;

  logic             v1_q, v2_q;
  logic [N-1:0]     a1_q, b1_q, s1_q, a2_q, b2_q;
  logic [N:0]       exact_w, approx_w, ed_w, ed2_q;

  logic [CNT_W-1:0] samples_q, samples_d, err_q, err_d, low_q, low_d;
  logic [ACC_W-1:0] ed_sum_q, ed_sum_d;
  logic [ACC_W:0]   sum_ext;
  logic [N:0]       ed_max_q, ed_max_d;
  logic [N-1:0]     max_a_q, max_a_d, max_b_q, max_b_d;

  always_comb in_ready_o = (state_q == S_RUN) && (accepted_q < target_q);
  assign accept   = in_valid_i && in_ready_o;
  assign start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Widen before adding so a lost carry-out registers as a 2^N error.
  assign exact_w  = {1'b0, a1_q} + {1'b0, b1_q};
  assign approx_w = {1'b0, s1_q};
  assign ed_w     = (exact_w >= approx_w) ? (exact_w - approx_w) : (approx_w - exact_w);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= accept;
      v2_q <= v1_q;
    end
    a1_q  <= in_a_i;
    b1_q  <= in_b_i;
    s1_q  <= in_sum_i;
    a2_q  <= a1_q;
    b2_q  <= b1_q;
    ed2_q <= ed_w;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      target_q   <= '0;
      accepted_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            target_q   <= target_i;
            accepted_q <= '0;
            if (target_i == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (accept) accepted_q <= accepted_q + 1'b1;
          if (accepted_q == target_q) begin
            state_q <= S_DRAIN;
            busy_q  <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (samples_q == target_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sum_ext = {1'b0, ed_sum_q} + {{(ACC_W-N){1'b0}}, ed2_q};

  always_comb begin
    samples_d = samples_q;
    err_d     = err_q;
    low_d     = low_q;
    ed_sum_d  = ed_sum_q;
    ed_max_d  = ed_max_q;
    max_a_d   = max_a_q;
    max_b_d   = max_b_q;
    if (start_ok) begin
      samples_d = '0;
      err_d     = '0;
      low_d     = '0;
      ed_sum_d  = '0;
      ed_max_d  = '0;
      max_a_d   = '0;
      max_b_d   = '0;
    end else if (v2_q) begin
      samples_d = samples_q + 1'b1;
      if (ed2_q != '0) begin
        err_d = err_q + 1'b1;
        if (ed2_q < (N+1)'(1 << K)) low_d = low_q + 1'b1;
      end
      ed_sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      // Strictly greater keeps the first sample among ties.
      if (ed2_q > ed_max_q) begin
        ed_max_d = ed2_q;
        max_a_d  = a2_q;
        max_b_d  = b2_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      samples_q <= '0;
      err_q     <= '0;
      low_q     <= '0;
      ed_sum_q  <= '0;
      ed_max_q  <= '0;
      max_a_q   <= '0;
      max_b_q   <= '0;
    end else begin
      samples_q <= samples_d;
      err_q     <= err_d;
      low_q     <= low_d;
      ed_sum_q  <= ed_sum_d;
      ed_max_q  <= ed_max_d;
      max_a_q   <= max_a_d;
      max_b_q   <= max_b_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign samples_o     = samples_q;
  assign err_count_o   = err_q;
  assign low_err_cnt_o = low_q;
  assign ed_sum_o      = ed_sum_q;
  assign ed_max_o      = ed_max_q;
  assign max_a_o       = max_a_q;
  assign max_b_o       = max_b_q;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Directed and random bench for approx_adder_err_monitor against an arithmetic reference model.
module tb_approx_adder_err_monitor;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, clear_i, in_valid_i;
  logic [31:0] target_i;
  logic [15:0] in_a_i, in_b_i, in_sum_i;
  logic        in_ready_o, busy_o, done_o;
  logic [31:0] samples_o, err_count_o, low_err_cnt_o;
  logic [47:0] ed_sum_o;
  logic [16:0] ed_max_o;
  logic [15:0] max_a_o, max_b_o;

  int n_assert = 0;
  int n_fail   = 0;

  longint m_samples, m_err, m_low, m_sum, m_max;
  longint m_ma, m_mb;
  int     acc_cnt;

  approx_adder_err_monitor dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .target_i(target_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_a_i(in_a_i), .in_b_i(in_b_i), .in_sum_i(in_sum_i),
    .busy_o(busy_o), .done_o(done_o), .samples_o(samples_o),
    .err_count_o(err_count_o), .low_err_cnt_o(low_err_cnt_o),
    .ed_sum_o(ed_sum_o), .ed_max_o(ed_max_o), .max_a_o(max_a_o), .max_b_o(max_b_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_samples = 0; m_err = 0; m_low = 0; m_sum = 0; m_max = 0; m_ma = 0; m_mb = 0;
    acc_cnt = 0;
  endtask

  // Error distance is simply |A + B - S| over unbounded integers.
  task automatic m_add(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
    longint ed;
    ed = longint'(a) + longint'(b) - longint'(s);
    if (ed < 0) ed = -ed;
    m_samples++;
    acc_cnt++;
    if (ed != 0) m_err++;
    if (ed != 0 && ed < 4096) m_low++;
    m_sum += ed;
    if (m_sum > 64'h0000_FFFF_FFFF_FFFF) m_sum = 64'h0000_FFFF_FFFF_FFFF;
    if (ed > m_max) begin m_max = ed; m_ma = a; m_mb = b; end
  endtask

  task automatic do_start(input int tgt);
    m_reset();
    target_i = tgt;
    start_i  = 1'b1;
    tick();
    start_i  = 1'b0;
  endtask

  task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
    bit ok = 0;
    in_valid_i = 1'b1; in_a_i = a; in_b_i = b; in_sum_i = s;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready_o;
      if (ok) m_add(a, b, s);
      tick();
    end
    in_valid_i = 1'b0;
    if (!ok) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 50 && !done_o; i++) tick();
    chk({tag, "_done"}, 64'(done_o), 64'd1);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_samples"}, 64'(samples_o), m_samples);
    chk({tag, "_err"},     64'(err_count_o), m_err);
    chk({tag, "_low"},     64'(low_err_cnt_o), m_low);
    chk({tag, "_edsum"},   64'(ed_sum_o), m_sum);
    chk({tag, "_edmax"},   64'(ed_max_o), m_max);
    chk({tag, "_maxa"},    64'(max_a_o), m_ma);
    chk({tag, "_maxb"},    64'(max_b_o), m_mb);
  endtask

  initial begin
    logic [15:0] ra, rb, rs, mask;
    int cyc;
    rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0;
    target_i = '0; in_a_i = '0; in_b_i = '0; in_sum_i = '0;
    m_reset();
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_ready", 64'(in_ready_o), 64'd0);
    chk("rst_busy",  64'(busy_o), 64'd0);
    chk("rst_done",  64'(done_o), 64'd0);
    chk_stats("rst");

    // Three samples, only the carry-loss one is wrong by 1.
    do_start(3);
    chk("run_busy", 64'(busy_o), 64'd1);
    send("t3a", 16'h1234, 16'h5678, 16'h68AC);
    send("t3b", 16'hFFFF, 16'h0001, 16'hFFFF);
    send("t3c", 16'hAAAA, 16'h5555, 16'hFFFF);
    wait_done("t3");
    chk("t3_err_const",  64'(err_count_o), 64'd1);
    chk("t3_edmax_const", 64'(ed_max_o), 64'd1);
    chk("t3_maxa_const", 64'(max_a_o), 64'hFFFF);
    chk_stats("t3");

    // Valid held for 5 cycles against a target of 2.
    do_start(2);
    in_valid_i = 1'b1; in_a_i = 16'h0100; in_b_i = 16'h0001; in_sum_i = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      if (in_ready_o) m_add(in_a_i, in_b_i, in_sum_i);
      tick();
    end
    in_valid_i = 1'b0;
    chk("hold_accepted", 64'(acc_cnt), 64'd2);
    chk("hold_ready_low", 64'(in_ready_o), 64'd0);
    wait_done("hold");
    chk_stats("hold");

    // Large error outside the low region.
    do_start(2);
    send("big_a", 16'h0F0F, 16'hF0F0, 16'h0000);
    send("big_b", 16'h0000, 16'h0000, 16'h0000);
    wait_done("big");
    chk("big_low_const",   64'(low_err_cnt_o), 64'd0);
    chk("big_edmax_const", 64'(ed_max_o), 64'h0FFFF);
    chk_stats("big");

    // Zero target goes straight to done with fresh stats.
    do_start(0);
    chk("t0_done", 64'(done_o), 64'd1);
    chk("t0_busy", 64'(busy_o), 64'd0);
    chk_stats("t0");

    // Clear while samples are still in flight.
    do_start(4);
    send("clr_a", 16'hFFFF, 16'hFFFF, 16'h0000);
    send("clr_b", 16'h8000, 16'h8000, 16'h0000);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    m_reset();
    chk("clr_busy",  64'(busy_o), 64'd0);
    chk("clr_done",  64'(done_o), 64'd0);
    chk("clr_ready", 64'(in_ready_o), 64'd0);
    chk_stats("clr_now");
    for (int i = 0; i < 5; i++) tick();
    chk_stats("clr_later");

    // Random run with roughly half the cycles offering a sample.
    do_start(10000);
    cyc = 0;
    while (acc_cnt < 10000 && cyc < 40000) begin
      ra = 16'($urandom); rb = 16'($urandom);
      case ($urandom_range(0, 3))
        0: mask = 16'h0000;
        1: mask = 16'h000F;
        2: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      rs = (ra + rb) ^ (16'($urandom) & mask);
      in_valid_i = 1'($urandom_range(0, 1));
      in_a_i = ra; in_b_i = rb; in_sum_i = rs;
      if (in_valid_i && in_ready_o) m_add(ra, rb, rs);
      tick();
      cyc++;
    end
    in_valid_i = 1'b0;
    chk("rnd_accepted", 64'(acc_cnt), 64'd10000);
    wait_done("rnd");
    chk_stats("rnd");
    for (int i = 0; i < 5; i++) tick();
    chk("rnd_done_hold", 64'(done_o), 64'd1);
    chk_stats("rnd_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
